// File: rtl/dma_tx_req_pkg.sv
// Shared types for the DMA TX requester: FSM states, command record and the
// saturating increment used by the drop counter and watchdog.
package dma_tx_req_pkg;

  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned TAG_W_DEF = 6;
  localparam int unsigned TMO_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEN_W_DEF-1:0] len;
    logic [TAG_W_DEF-1:0] tag;
  } cmd_t;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == '1) ? v : v + TMO_W'(1);
  endfunction

endpackage

// File: rtl/dma_tx_req_if.sv
// Command, arbitration and TX stream signals of one DMA TX requester channel.
// master: the requester itself; slave: the command source/arbiter/sink side.
interface dma_tx_req_if
  import dma_tx_req_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [TAG_W-1:0] cmd_tag;
  logic             req;
  logic             tkn;
  logic             tkn_ack;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_sop;
  logic             tx_eop;
  logic [TAG_W-1:0] tx_tag;

  modport master (
    input  cmd_valid, cmd_len, cmd_tag, tkn, tx_ready,
    output cmd_ready, req, tkn_ack, tx_valid, tx_sop, tx_eop, tx_tag
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_tag, tkn, tx_ready,
    input  cmd_ready, req, tkn_ack, tx_valid, tx_sop, tx_eop, tx_tag
  );

endinterface

// File: rtl/dma_tx_req_fifo.sv
// Synchronous show-ahead FIFO of command records with occupancy outputs.
module dma_tx_req_fifo
  import dma_tx_req_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  T                         wr_data,
  input  logic                     rd_en,
  output T                         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_wr;
  logic           do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dma_tx_req.sv
// Per-channel DMA TX requester: queues commands, arbitrates via req/tkn/tkn_ack
// and streams each granted transfer. Optional watchdog: DMA_TX_REQ_TIMEOUT_EN.
module dma_tx_req
  import dma_tx_req_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic                   user_clk,
  input  logic                   reset,
  dma_tx_req_if.master           bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic [15:0]            drop_cnt,
  output logic                   err_timeout
);

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [TAG_W-1:0] tag;
  } cmd_w_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TMO_CYC < 1 || TMO_CYC >= (1 << TMO_W)) begin : g_param_chk
    $error("dma_tx_req: DEPTH must be a power of two >= 2 and TMO_CYC fit the watchdog");
  end

  state_e           state;
  cmd_w_t           wr_cmd;
  cmd_w_t           head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             run_q;
  logic             cmd_acc;
  logic             beat_hs;
  logic             req_q;
  logic             sop_q;
  logic             eop_q;
  logic [TAG_W-1:0] tag_q;
  logic [LEN_W-1:0] beat_rem;

  // run_q keeps cmd_ready low while in reset and for the first clock after it
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  assign bus.cmd_ready = run_q & ~fifo_full;
  assign cmd_acc       = bus.cmd_valid & bus.cmd_ready;
  assign fifo_wr       = cmd_acc & (bus.cmd_len != '0);
  assign fifo_rd       = (state == IDLE) & ~fifo_empty;
  assign wr_cmd        = '{len: bus.cmd_len, tag: bus.cmd_tag};

  dma_tx_req_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk     (user_clk),
    .rst     (reset),
    .wr_en   (fifo_wr),
    .wr_data (wr_cmd),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Grant is combinational, so valid and the last-beat ack follow tkn directly
  assign bus.tx_valid = (state == XFER) & bus.tkn;
  assign beat_hs      = bus.tx_valid & bus.tx_ready;
  assign bus.tkn_ack  = beat_hs & eop_q;
  assign bus.req      = req_q;
  assign bus.tx_sop   = sop_q;
  assign bus.tx_eop   = eop_q;
  assign bus.tx_tag   = tag_q;
  assign busy         = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      tag_q    <= '0;
      beat_rem <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= REQ;
            req_q    <= 1'b1;
            sop_q    <= 1'b1;
            eop_q    <= (head.len == LEN_W'(1));
            tag_q    <= head.tag;
            beat_rem <= head.len;
          end
        end
        REQ: begin
          if (bus.tkn) state <= XFER;
        end
        XFER: begin
          if (beat_hs) begin
            sop_q    <= 1'b0;
            beat_rem <= beat_rem - LEN_W'(1);
            if (eop_q) begin
              state <= IDLE;
              req_q <= 1'b0;
              eop_q <= 1'b0;
            end else begin
              eop_q <= (beat_rem == LEN_W'(2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset)                            drop_cnt <= '0;
    else if (cmd_acc && bus.cmd_len == '0) drop_cnt <= sat_inc(drop_cnt);
  end

`ifdef DMA_TX_REQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE || beat_hs) tmo_cnt <= '0;
      else if (req_q)               tmo_cnt <= sat_inc(tmo_cnt);
      if (tmo_cnt == TMO_W'(TMO_CYC)) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dma_tx_req.sv
// Randomised and directed bench for dma_tx_req against a beat-queue model.
module tb_dma_tx_req;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned TMO_CYC = 64;

  logic                   user_clk = 1'b0;
  logic                   reset    = 1'b1;
  logic                   tkn_en   = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   busy;
  logic [15:0]            drop_cnt;
  logic                   err_timeout;

  dma_tx_req_if #(.LEN_W(LEN_W), .TAG_W(TAG_W)) bus ();

  dma_tx_req #(
    .DEPTH   (DEPTH),
    .LEN_W   (LEN_W),
    .TAG_W   (TAG_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .user_clk    (user_clk),
    .reset       (reset),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .drop_cnt    (drop_cnt),
    .err_timeout (err_timeout)
  );

  always #5 user_clk = ~user_clk;

  // Arbiter stand-in: grants whenever asked unless the bench withholds it
  assign bus.tkn = bus.req & tkn_en;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted non-zero command becomes len expected beats, in order
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             sop;
    logic             eop;
  } beat_t;

  beat_t            exp_q[$];
  int               drop_m  = 0;
  int               hs_cnt  = 0;
  int               ack_cnt = 0;
  logic             prev_stall = 1'b0;
  logic             prev_ack   = 1'b0;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_sop;
  logic             prev_eop;

  always @(negedge user_clk) begin
    beat_t b;
    if (reset) begin
      exp_q.delete();
      drop_m     = 0;
      prev_stall = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      check("drop_cnt", 32'(drop_cnt), drop_m);
      check("level_range", 32'(fifo_level <= DEPTH), 1);
      if (exp_q.size() != 0) check("busy_with_work", 32'(busy), 1);
      if (prev_ack) check("req_gap_after_ack", 32'(bus.req), 0);
`ifndef DMA_TX_REQ_TIMEOUT_EN
      check("err_timeout_off", 32'(err_timeout), 0);
`endif
      if (bus.tx_valid) begin
        check("valid_needs_grant", 32'(bus.req & bus.tkn), 1);
        if (prev_stall) begin
          check("hold_tag", 32'(bus.tx_tag), 32'(prev_tag));
          check("hold_sop", 32'(bus.tx_sop), 32'(prev_sop));
          check("hold_eop", 32'(bus.tx_eop), 32'(prev_eop));
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        check("beat_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("beat_tag", 32'(bus.tx_tag), 32'(b.tag));
          check("beat_sop", 32'(bus.tx_sop), 32'(b.sop));
          check("beat_eop", 32'(bus.tx_eop), 32'(b.eop));
          check("beat_ack", 32'(bus.tkn_ack), 32'(b.eop));
        end
        hs_cnt++;
        if (bus.tkn_ack) ack_cnt++;
      end else begin
        check("ack_without_beat", 32'(bus.tkn_ack), 0);
      end
      prev_stall = bus.tx_valid & ~bus.tx_ready;
      prev_tag   = bus.tx_tag;
      prev_sop   = bus.tx_sop;
      prev_eop   = bus.tx_eop;
      prev_ack   = bus.tkn_ack;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_len == '0) begin
          if (drop_m < 65535) drop_m++;
        end else begin
          for (int i = 0; i < int'(bus.cmd_len); i++) begin
            b.tag = bus.cmd_tag;
            b.sop = (i == 0);
            b.eop = (i == int'(bus.cmd_len) - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  task automatic next();
    @(posedge user_clk);
    #2;
  endtask

  task automatic smp();
    @(negedge user_clk);
    #1;
  endtask

  task automatic push(input int len, input int tag);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_tag   = TAG_W'(tag);
    smp();
    while (!bus.cmd_ready && guard < 200) begin
      next();
      smp();
      guard++;
    end
    check("push_accepted", 32'(bus.cmd_ready), 1);
    next();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    smp();
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      next();
      smp();
      n++;
    end
    check("drain_in_budget", 32'(n < limit), 1);
    next();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1, "time limit");
  end

  initial begin
    int hs0, ack0, run, guard;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_tag   = '0;
    bus.tx_ready  = 1'b0;

    repeat (3) next();
    smp();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst_req", 32'(bus.req), 0);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_err", 32'(err_timeout), 0);
    next();
    reset = 1'b0;
    next();

    // Single command len=3 tag=5, grant follows req
    tkn_en = 1'b1;
    bus.tx_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len = LEN_W'(3);
    bus.cmd_tag = TAG_W'(5);
    smp();
    check("t1_cmd_ready", 32'(bus.cmd_ready), 1);
    next();
    bus.cmd_valid = 1'b0;
    smp(); check("t1_req_t1", 32'(bus.req), 0);
    next();
    smp(); check("t1_req_t2", 32'(bus.req), 1);
           check("t1_valid_t2", 32'(bus.tx_valid), 0);
    next();
    smp(); check("t1_valid_t3", 32'(bus.tx_valid), 1);
           check("t1_sop_t3", 32'(bus.tx_sop), 1);
           check("t1_eop_t3", 32'(bus.tx_eop), 0);
           check("t1_tag_t3", 32'(bus.tx_tag), 5);
           check("t1_ack_t3", 32'(bus.tkn_ack), 0);
    next();
    smp(); check("t1_valid_t4", 32'(bus.tx_valid), 1);
           check("t1_sop_t4", 32'(bus.tx_sop), 0);
           check("t1_eop_t4", 32'(bus.tx_eop), 0);
    next();
    smp(); check("t1_valid_t5", 32'(bus.tx_valid), 1);
           check("t1_eop_t5", 32'(bus.tx_eop), 1);
           check("t1_ack_t5", 32'(bus.tkn_ack), 1);
    next();
    smp(); check("t1_req_t6", 32'(bus.req), 0);
           check("t1_valid_t6", 32'(bus.tx_valid), 0);
    next();

    // Backpressure: tx_ready toggles every cycle
    hs0 = hs_cnt; ack0 = ack_cnt;
    bus.tx_ready = 1'b0;
    push(2, 9);
    guard = 0;
    smp();
    while ((exp_q.size() != 0 || busy) && guard < 50) begin
      next();
      bus.tx_ready = ~bus.tx_ready;
      smp();
      guard++;
    end
    check("bp_in_budget", 32'(guard < 50), 1);
    next();
    bus.tx_ready = 1'b1;
    check("bp_beats", hs_cnt - hs0, 2);
    check("bp_acks", ack_cnt - ack0, 1);

    // Grant loss after beat 2 of 4
    hs0 = hs_cnt; ack0 = ack_cnt;
    push(4, 17);
    guard = 0;
    smp();
    while (hs_cnt - hs0 < 2 && guard < 50) begin
      next();
      smp();
      guard++;
    end
    check("gl_two_beats", hs_cnt - hs0, 2);
    next();
    tkn_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("gl_gap_valid", 32'(bus.tx_valid), 0);
      check("gl_gap_req", 32'(bus.req), 1);
      next();
    end
    check("gl_beats_at_gap", hs_cnt - hs0, 2);
    tkn_en = 1'b1;
    drain(50);
    check("gl_beats", hs_cnt - hs0, 4);
    check("gl_acks", ack_cnt - ack0, 1);

    // Fill/drain: one transfer stalled in REQ, then 8 commands fill the FIFO
    hs0 = hs_cnt; ack0 = ack_cnt;
    tkn_en = 1'b0;
    push(1, 63);
    for (int k = 0; k < 8; k++) push(k + 1, k);
    smp();
    check("fill_cmd_ready", 32'(bus.cmd_ready), 0);
    check("fill_level", 32'(fifo_level), 8);
    next();
    tkn_en = 1'b1;
    run = -1;
    guard = 0;
    smp();
    while ((exp_q.size() != 0 || busy) && guard < 500) begin
      if (bus.tkn_ack) run = 0;
      else if (run >= 0) begin
        if (!bus.req) run++;
        else begin
          check("fill_gap_len", run, 1);
          run = -1;
        end
      end
      next();
      smp();
      guard++;
    end
    check("fill_in_budget", 32'(guard < 500), 1);
    next();
    check("fill_beats", hs_cnt - hs0, 37);
    check("fill_acks", ack_cnt - ack0, 9);

    // Reset during beat 2 of 5, with a second command queued
    hs0 = hs_cnt;
    push(5, 21);
    push(2, 22);
    guard = 0;
    smp();
    while (hs_cnt - hs0 < 1 && guard < 50) begin
      next();
      smp();
      guard++;
    end
    next();
    ack0 = ack_cnt;
    reset = 1'b1;
    smp();
    check("mr_req", 32'(bus.req), 0);
    check("mr_valid", 32'(bus.tx_valid), 0);
    check("mr_ack", 32'(bus.tkn_ack), 0);
    check("mr_sop", 32'(bus.tx_sop), 0);
    check("mr_eop", 32'(bus.tx_eop), 0);
    check("mr_tag", 32'(bus.tx_tag), 0);
    check("mr_cmd_ready", 32'(bus.cmd_ready), 0);
    check("mr_level", 32'(fifo_level), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_drop", 32'(drop_cnt), 0);
    check("mr_err", 32'(err_timeout), 0);
    next();
    reset = 1'b0;
    hs0 = hs_cnt;
    repeat (6) next();
    check("mr_no_ack", ack_cnt - ack0, 0);
    check("mr_no_beats", hs_cnt - hs0, 0);

    // Zero-length command then len=1
    hs0 = hs_cnt; ack0 = ack_cnt;
    push(0, 3);
    push(1, 4);
    drain(50);
    check("zl_drop", 32'(drop_cnt), 1);
    check("zl_beats", hs_cnt - hs0, 1);
    check("zl_acks", ack_cnt - ack0, 1);

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bus.cmd_valid = ($urandom_range(0, 2) == 0);
      bus.cmd_len   = LEN_W'($urandom_range(0, 6));
      bus.cmd_tag   = TAG_W'($urandom);
      bus.tx_ready  = ($urandom_range(0, 3) != 0);
      tkn_en        = ($urandom_range(0, 4) != 0);
      next();
    end
    bus.cmd_valid = 1'b0;
    bus.tx_ready  = 1'b1;
    tkn_en        = 1'b1;
    drain(2000);
    smp();
    check("rnd_level", 32'(fifo_level), 0);
    check("rnd_busy", 32'(busy), 0);
    check("rnd_queue", exp_q.size(), 0);
    next();

`ifdef DMA_TX_REQ_TIMEOUT_EN
    reset = 1'b1;
    next();
    reset = 1'b0;
    next();
    smp();
    check("tmo_clear", 32'(err_timeout), 0);
    next();
    tkn_en = 1'b0;
    push(1, 40);
    repeat (TMO_CYC - 2) next();
    smp();
    check("tmo_before", 32'(err_timeout), 0);
    repeat (8) next();
    smp();
    check("tmo_set", 32'(err_timeout), 1);
    next();
    tkn_en = 1'b1;
    drain(50);
    smp();
    check("tmo_sticky", 32'(err_timeout), 1);
    next();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_tx_req.md
Name: dma_tx_req

Overview:
- Per-channel requester on the DMA TX side; the client end of the req/tkn/tkn_ack round-robin arbitration handshake.
- Buffers transfer commands, each a beat count plus a tag, and raises req to the shared TX arbiter.
- While holding the token, drives the granted transfer beat by beat onto the shared TX stream.
- Pulses tkn_ack on the last beat so the arbiter rotates priority. One instance per channel, N instances per arbiter.

Parameters:
- DEPTH, 8: command FIFO entries; power of 2, ≥2.
- LEN_W, 8: cmd_len width; transfer length in beats, 1..2^LEN_W-1.
- TAG_W, 6: cmd_tag width; tag passed through to the TX stream.
- TMO_CYC, 1024: watchdog threshold in cycles; used only with the optional feature.

Ports:
- user_clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: FIFO not full.
- cmd_len, in, LEN_W: beats in the transfer.
- cmd_tag, in, TAG_W: transfer tag.
- req, out, 1: request to the arbiter.
- tkn, in, 1: grant from the arbiter; combinational, may drop while req is high.
- tkn_ack, out, 1: one-cycle pulse on the last-beat handshake.
- tx_valid, out, 1: beat valid.
- tx_ready, in, 1: downstream accepts the beat.
- tx_sop, out, 1: first beat of the transfer.
- tx_eop, out, 1: last beat of the transfer.
- tx_tag, out, TAG_W: tag of the current transfer.
- fifo_level, out, $clog2(DEPTH)+1: current FIFO occupancy.
- busy, out, 1: state != IDLE or FIFO not empty.
- drop_cnt, out, 16: saturating count of dropped zero-length commands.
- err_timeout, out, 1: sticky watchdog flag (optional feature).

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0. Reset asserted mid-transfer aborts the transfer immediately; no tkn_ack is issued.
- FIFO write: on cmd_valid & cmd_ready. cmd_ready = !full, registered from the level.
- Zero-length commands: cmd_len==0 is accepted but never written to the FIFO; drop_cnt increments (saturates at 0xFFFF).
- State IDLE:
  - req=0.
  - If the FIFO is non-empty: pop the head, load beat_rem=len and cur_tag=tag, go to REQ.
  - Latency: a command written at cycle t into an empty FIFO gives req=1 at t+2.
- State REQ:
  - req=1, tx_valid=0.
  - On tkn=1, go to XFER next cycle. The arbiter does not see tkn_ack until the last beat, so tkn remains valid.
- State XFER:
  - req=1, tx_valid = tkn. tx_sop = first beat not yet accepted; tx_eop = (beat_rem==1).
  - A beat is consumed on tx_valid & tx_ready; beat_rem decrements.
  - If tkn drops, tx_valid drops the same cycle. The beat and its sop/eop/tag are held; req stays high; the transfer resumes when tkn returns.
  - Last-beat handshake: tkn_ack=1 in that same cycle (combinational from state, tkn, tx_ready and eop), then go to IDLE.
- Inter-transfer gap: req=0 for at least one cycle between transfers, which is the IDLE cycle.
- tx_tag and tx_eop are stable while tx_valid=1 and tx_ready=0.
- Simultaneous FIFO push and pop: both happen; level unchanged. A push to a full FIFO does not occur because cmd_ready=0.
- Pop timing: the pop happens in IDLE, so a FIFO full at DEPTH accepts a new command in the cycle after the pop.

Optional Feature:
- Macro DMA_TX_REQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments every cycle with req=1 and no tx handshake; it clears on a handshake and in IDLE.
  - When the counter reaches TMO_CYC, err_timeout sets and stays set until reset. Transfer behaviour is unchanged.
- Undefined: counter absent; err_timeout tied to 0.

Decomposition:
- Package dma_tx_req_pkg:
  - state enum {IDLE, REQ, XFER}.
  - Command struct {len, tag}, with LEN_W/TAG_W default localparams.
  - Timeout counter width constant.
- Sub-module dma_tx_req_fifo: synchronous FIFO of command structs, DEPTH entries, with full/empty/level outputs.
- FSM, beat counter and watchdog live in the top module.

Test Plan:
- Single command len=3, tag=5, tkn tied to req, tx_ready=1:
  - req rises at t+2; three beats at t+3..t+5.
  - sop only on the first beat, eop and tkn_ack only on the third; req=0 at t+6.
- Backpressure: len=2 with tx_ready toggling 0/1 each cycle:
  - beats held stable; exactly 2 handshakes; one tkn_ack pulse.
- Grant loss: len=4, tkn forced to 0 for 3 cycles after beat 2:
  - tx_valid=0 with req=1 during the gap; beats 3 and 4 are delivered after tkn returns; total beats = 4.
- Fill/drain: 8 back-to-back commands (len=1..8) with tkn delayed:
  - cmd_ready=0 after the 8th is accepted; drain yields 36 beats in order with tags 0..7.
  - req=0 exactly one cycle between transfers.
- Zero length: cmd_len=0 then len=1:
  - drop_cnt=1; only one transfer issued.
- Reset mid-XFER at beat 2 of 5:
  - all outputs 0 immediately; FIFO empty; no tkn_ack.
  - With DMA_TX_REQ_TIMEOUT_EN and tkn held 0 for TMO_CYC cycles, err_timeout=1 and stays set.
